// File: rtl/threshold_calibrator_if.sv
// rtl/threshold_calibrator_if.sv - tap stream bundle feeding the threshold calibrator
`timescale 1ns/1ps
interface threshold_calibrator_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    logic                        tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] tdata;
    logic                        tready;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/threshold_calibrator.sv
// rtl/threshold_calibrator.sv - min/max window calibration of the fringe counter's hysteresis thresholds
// Optional feature: THRESHOLD_CAL_QUAD_CHECK_EN also requires channel B to swing by MIN_SPAN.
`timescale 1ns/1ps
module threshold_calibrator #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int WINDOW_LOG       = 16,
    parameter int HYST_SHIFT       = 2,
    parameter int MIN_SPAN         = 64,
    parameter int DEFAULT_LOWER    = -1024,
    parameter int DEFAULT_UPPER    = 1024
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    threshold_calibrator_if.slave                  S_AXIS,
    input  logic                                   CAL_start,
    input  logic                                   CAL_abort,
    output logic                                   CAL_busy,
    output logic                                   CAL_done,
    output logic                                   CAL_error,
    output logic signed [AXIS_TDATA_WIDTH/2-1:0]   FC_lower_threshold,
    output logic signed [AXIS_TDATA_WIDTH/2-1:0]   FC_upper_threshold
);
    localparam int HALF = AXIS_TDATA_WIDTH / 2;

    localparam logic signed [HALF-1:0] CODE_MAX   = {1'b0, {(HALF-1){1'b1}}};
    localparam logic signed [HALF-1:0] CODE_MIN   = {1'b1, {(HALF-1){1'b0}}};
    localparam logic signed [HALF-1:0] RST_LOWER  = DEFAULT_LOWER[HALF-1:0];
    localparam logic signed [HALF-1:0] RST_UPPER  = DEFAULT_UPPER[HALF-1:0];
    localparam logic signed [HALF:0]   MIN_SPAN_X = MIN_SPAN[HALF:0];
    localparam logic [WINDOW_LOG-1:0]  COUNT_LAST = '1;
    localparam logic [WINDOW_LOG-1:0]  COUNT_ONE  = WINDOW_LOG'(1);

    typedef enum logic [1:0] {IDLE, ACQUIRE, COMPUTE} state_t;

    state_t                  state_q, state_d;
    logic [WINDOW_LOG-1:0]   count_q, count_d;
    logic signed [HALF-1:0]  min_a_q, min_a_d, max_a_q, max_a_d;
    logic signed [HALF-1:0]  lower_q, lower_d, upper_q, upper_d;
    logic                    done_q, done_d, error_q, error_d;

    logic signed [HALF-1:0]  sample_a;
    logic signed [HALF-1:0]  sample_b;
    logic                    window_end;
    logic signed [HALF:0]    max_a_x, min_a_x, sum_a, center, span_a, hyst;
    logic signed [HALF:0]    lower_calc, upper_calc;
    logic                    span_ok;
    logic                    calc_unused;

    assign sample_a   = S_AXIS.tdata[HALF-1:0];
    assign sample_b   = S_AXIS.tdata[2*HALF-1:HALF];
    assign window_end = S_AXIS.tvalid && (count_q == COUNT_LAST);

    // One extra bit keeps max+min and max-min exact even at full scale.
    assign max_a_x    = {max_a_q[HALF-1], max_a_q};
    assign min_a_x    = {min_a_q[HALF-1], min_a_q};
    assign sum_a      = max_a_x + min_a_x;
    assign center     = sum_a >>> 1;
    assign span_a     = max_a_x - min_a_x;
    assign hyst       = span_a >> HYST_SHIFT;
    assign lower_calc = center - hyst;
    assign upper_calc = center + hyst;

`ifdef THRESHOLD_CAL_QUAD_CHECK_EN
    logic signed [HALF-1:0] min_b_q, min_b_d, max_b_q, max_b_d;
    logic signed [HALF:0]   span_b;

    assign span_b  = {max_b_q[HALF-1], max_b_q} - {min_b_q[HALF-1], min_b_q};
    assign span_ok = (span_a >= MIN_SPAN_X) && (span_b >= MIN_SPAN_X);

    always_comb begin
        min_b_d = min_b_q;
        max_b_d = max_b_q;
        if (state_q == IDLE && CAL_start) begin
            min_b_d = CODE_MAX;
            max_b_d = CODE_MIN;
        end else if (state_q == ACQUIRE && S_AXIS.tvalid) begin
            if (sample_b < min_b_q) min_b_d = sample_b;
            if (sample_b > max_b_q) max_b_d = sample_b;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            min_b_q <= CODE_MAX;
            max_b_q <= CODE_MIN;
        end else begin
            min_b_q <= min_b_d;
            max_b_q <= max_b_d;
        end
    end

    assign calc_unused = ^{lower_calc[HALF], upper_calc[HALF], span_b[HALF]};
`else
    assign span_ok     = (span_a >= MIN_SPAN_X);
    assign calc_unused = ^{lower_calc[HALF], upper_calc[HALF], sample_b};
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort outranks window completion; start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (CAL_start) state_d = ACQUIRE;
            ACQUIRE: begin
                if (CAL_abort)       state_d = IDLE;
                else if (window_end) state_d = COMPUTE;
            end
            COMPUTE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        S_AXIS.tready      = 1'b1;
        CAL_busy           = (state_q != IDLE);
        CAL_done           = done_q;
        CAL_error          = error_q;
        FC_lower_threshold = lower_q;
        FC_upper_threshold = upper_q;
    end

    always_comb begin
        count_d = count_q;
        min_a_d = min_a_q;
        max_a_d = max_a_q;
        lower_d = lower_q;
        upper_d = upper_q;
        done_d  = 1'b0;
        error_d = error_q;
        case (state_q)
            IDLE: begin
                if (CAL_start) begin
                    count_d = '0;
                    min_a_d = CODE_MAX;
                    max_a_d = CODE_MIN;
                    error_d = 1'b0;
                end
            end
            ACQUIRE: begin
                if (S_AXIS.tvalid) begin
                    count_d = count_q + COUNT_ONE;
                    if (sample_a < min_a_q) min_a_d = sample_a;
                    if (sample_a > max_a_q) max_a_d = sample_a;
                end
            end
            COMPUTE: begin
                // Both thresholds land on the same edge so the tracker never sees a mixed pair.
                if (!CAL_abort) begin
                    if (span_ok) begin
                        lower_d = lower_calc[HALF-1:0];
                        upper_d = upper_calc[HALF-1:0];
                        done_d  = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            count_q <= '0;
            min_a_q <= CODE_MAX;
            max_a_q <= CODE_MIN;
            lower_q <= RST_LOWER;
            upper_q <= RST_UPPER;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            count_q <= count_d;
            min_a_q <= min_a_d;
            max_a_q <= max_a_d;
            lower_q <= lower_d;
            upper_q <= upper_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end
endmodule
